// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one registered signed adder between requesters.
// Grant in IDLE, add in CALC, hold the result in RESP until accepted.
module add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DW      = 16,
  parameter int IDW     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*DW-1:0] req_dina,
  input  logic [NUM_REQ*DW-1:0] req_dinb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DW-1:0]         rsp_data,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_ovf,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    RESP
  } state_t;

  state_t state, state_nx;

  logic [IDW-1:0]     rr_ptr;
  logic [IDW-1:0]     ptr_nx;
  logic [IDW-1:0]     gnt;
  logic [IDW-1:0]     id_q;
  logic               found;
  logic [NUM_REQ-1:0] onehot;
  logic [DW-1:0]      sel_a, sel_b;
  logic [DW-1:0]      opa, opb;
  logic [DW-1:0]      sum;
  logic               ovf;

  // first valid requester at or after rr_ptr, wrapping
  always_comb begin : arb
    int idx;
    idx    = 0;
    found  = 1'b0;
    gnt    = '0;
    onehot = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found       = 1'b1;
        gnt         = IDW'(idx);
        onehot[idx] = 1'b1;
        sel_a       = req_dina[idx*DW +: DW];
        sel_b       = req_dinb[idx*DW +: DW];
      end
    end
  end

  always_comb begin : fsm
    state_nx  = state;
    req_ready = '0;
    unique case (state)
      IDLE: begin
        req_ready = onehot;
        if (found) state_nx = CALC;
      end
      CALC: state_nx = RESP;
      RESP: if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);

  assign sum = opa + opb;
  assign ovf = (opa[DW-1] == opb[DW-1]) &&
               (sum[DW-1] != opa[DW-1]);

  assign ptr_nx = (id_q == IDW'(NUM_REQ-1)) ?
                  '0 : id_q + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      opa      <= '0;
      opb      <= '0;
      id_q     <= '0;
      rsp_data <= '0;
      rsp_id   <= '0;
      rsp_ovf  <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && found) begin
        opa  <= sel_a;
        opb  <= sel_b;
        id_q <= gnt;
      end
      if (state == CALC) begin
        rsp_data <= sum;
        rsp_ovf  <= ovf;
        rsp_id   <= id_q;
      end
      // pointer moves on response acceptance only
      if (state == RESP && rsp_ready) rr_ptr <= ptr_nx;
    end
  end

endmodule

// File: doc/add_arbiter.md
Name: add_arbiter

Overview:
- Shares one signed DW-bit adder between NUM_REQ requesters.
- Each requester presents an operand pair with a valid/ready handshake.
- The block grants requesters round-robin, latches the pair, computes the registered sum, and returns it with the winner's ID over a valid/ready response channel.
- Sits between the per-channel sample producers and the accumulation/output stage.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DW, 16, operand and result width, signed two's complement.
- IDW, 2, requester ID width; must satisfy 2^IDW >= NUM_REQ.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_dina  in  NUM_REQ*DW  packed operand A; requester i uses bits [i*DW +: DW].
- req_dinb  in  NUM_REQ*DW  packed operand B, same packing.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  downstream accepts result.
- rsp_data  out  DW  signed sum, wrapped to DW bits.
- rsp_id  out  IDW  index of the requester that produced rsp_data.
- rsp_ovf  out  1  signed overflow of this sum.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous and active-low (rst = 0 resets).
- Reset values: state = IDLE, rr_ptr = 0, operand registers = 0, rsp_data = 0, rsp_id = 0, rsp_ovf = 0, rsp_valid = 0, busy = 0, req_ready = 0.
- States:
  - IDLE: go to CALC when any req_valid is high.
  - CALC: always go to RESP after one cycle.
  - RESP: go to IDLE when rsp_ready is high; otherwise hold.
- Arbitration (IDLE only, combinational):
  - Winner g is the first index with req_valid set, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[g] = 1 in that same cycle; the handshake completes when req_valid[g] and req_ready[g] are both high at the clock edge.
  - On that edge: latch req_dina[g] and req_dinb[g] into the operand registers, latch g as the ID, enter CALC.
  - req_ready = 0 in CALC and RESP.
- CALC:
  - sum = opa + opb, truncated to DW bits (two's complement wrap, no saturation).
  - ovf = 1 when opa and opb have the same sign and sum's sign differs.
  - Register sum, ovf and ID into the rsp_* outputs; enter RESP.
- RESP:
  - rsp_valid = 1; rsp_data, rsp_id and rsp_ovf stay stable until accepted.
  - When rsp_valid and rsp_ready are both high at an edge: rr_ptr = (g+1) mod NUM_REQ, enter IDLE, rsp_valid drops the next cycle.
  - rsp_data, rsp_id and rsp_ovf hold their last values after the drop.
- Timing:
  - Latency: request accepted at edge T, rsp_valid high from cycle T+2.
  - Peak throughput: one result per 3 cycles when rsp_ready is tied high.
- Boundary conditions:
  - Requester deasserts req_valid while not granted: allowed, no effect.
  - Granted requester must hold its operands only for the accept cycle.
  - All requesters valid: service order 0,1,2,3,0,... starting from rr_ptr; no requester waits more than NUM_REQ-1 grants.
  - Single requester continuously valid: it is re-granted every transaction.
  - Pointer wrap: after serving index NUM_REQ-1, rr_ptr = 0.
  - rsp_ready already high when RESP is entered: accepted in the first RESP cycle.
  - Reset asserted mid-transaction (CALC or RESP): all state returns to reset values immediately; the pending result is discarded and the requester is not re-notified.
  - Reset release: first possible grant on the first edge with rst = 1.
  - rr_ptr advances only on response acceptance, never on grant.

Test Plan:
- Reset, then req_valid[1] with A=100, B=-30 (DW=16) -> req_ready = 4'b0010 in the request cycle; 2 cycles later rsp_data=70, rsp_id=1, rsp_ovf=0, rsp_valid=1.
- req_valid=4'b1111 held, rsp_ready tied high -> grant order 0,1,2,3,0; rsp_valid asserted once every 3 cycles.
- A=32767, B=1 -> rsp_data=-32768, rsp_ovf=1; A=-32768, B=-1 -> rsp_data=32767, rsp_ovf=1; A=-5, B=5 -> 0, ovf=0.
- rsp_ready held low for 5 cycles in RESP -> rsp_valid and rsp_data stable, req_ready=0 throughout, other requests stay pending; first grant comes after rsp_ready rises.
- rst pulled low during CALC -> rsp_valid=0 and busy=0 immediately; after release with req_valid=4'b0100 -> grant to requester 2 (rr_ptr reset to 0).
- req_valid=4'b1001 after serving requester 0 -> next grant to requester 3, then to requester 0 (pointer wrap).
